// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer and its neighbours.
package fft_pkg;

  localparam int unsigned FFT_WIDTH     = 16;
  localparam int unsigned OVERRUN_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StStart,
    StWait,
    StUnload
  } fft_seq_state_t;

  typedef struct packed {
    logic [FFT_WIDTH-1:0] re;
    logic [FFT_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_seq_if.sv
// Signal bundle between the sample front end, the FFT core and the result consumer.
interface fft_frame_seq_if
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_2   = 5
);

  logic                     run;
  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH-1:0]         s_data;
  logic                     fft_reset;
  logic                     fft_load;
  logic [WIDTH-1:0]         fft_rd;
  logic                     fft_start;
  logic                     fft_done;
  logic [2*WIDTH-1:0]       fft_wd;
  logic                     m_valid;
  logic [2*WIDTH-1:0]       m_data;
  logic [N_2-1:0]           m_index;
  logic                     m_last;
  logic                     busy;
  logic                     frame_done;
  logic                     timeout_err;
  logic [OVERRUN_CNT_W-1:0] overrun_cnt;

  // Sequencer side
  modport master (
    input  run, s_valid, s_data, fft_done, fft_wd,
    output s_ready, fft_reset, fft_load, fft_rd, fft_start,
    output m_valid, m_data, m_index, m_last, busy, frame_done, timeout_err, overrun_cnt
  );

  // Environment side
  modport slave (
    output run, s_valid, s_data, fft_done, fft_wd,
    input  s_ready, fft_reset, fft_load, fft_rd, fft_start,
    input  m_valid, m_data, m_index, m_last, busy, frame_done, timeout_err, overrun_cnt
  );

endinterface

// File: rtl/fft_seq_watchdog.sv
// Cycle counter for the WAIT state; o_expired flags the last permitted cycle.
module fft_seq_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th enabled cycle so the FSM leaves after exactly TIMEOUT cycles.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fft_frame_seq.sv
// Steps the FFT core through clear/load/start/wait/unload once per frame.
// Optional FFT_SEQ_OVERRUN_CNT_EN adds a saturating dropped-sample counter.
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_2     = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  fft_frame_seq_if.master bus
);

  localparam int unsigned    N        = 1 << N_2;
  localparam logic [N_2-1:0] LAST_IDX = N_2'(N - 1);

  fft_seq_state_t     r_state, w_state_next;
  logic [N_2-1:0]     r_cnt;
  logic               r_m_valid, r_m_last, r_frame_done, r_timeout_err;
  logic [2*WIDTH-1:0] r_m_data;
  logic [N_2-1:0]     r_m_index;

  logic               w_s_ready, w_fft_load, w_fft_start, w_fft_reset;
  logic [WIDTH-1:0]   w_fft_rd;
  logic               w_accept, w_capture, w_last, w_timeout, w_wd_expired;

  assign w_accept  = (r_state == StLoad) && bus.s_valid;
  assign w_capture = bus.fft_done && ((r_state == StWait) || (r_state == StUnload));
  assign w_last    = (r_cnt == LAST_IDX);
  assign w_timeout = (r_state == StWait) && !bus.fft_done && w_wd_expired;

  fft_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state == StStart),
    .i_en      (r_state == StWait),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (bus.run) w_state_next = StClear;
      StClear:  w_state_next = StLoad;
      StLoad: begin
        if (!bus.run) begin
          w_state_next = StIdle;
        end else if (w_accept && w_last) begin
          w_state_next = StStart;
        end
      end
      StStart:  w_state_next = StWait;
      StWait: begin
        if (bus.fft_done) begin
          w_state_next = StUnload;
        end else if (w_wd_expired) begin
          w_state_next = StIdle;
        end
      end
      StUnload: if (w_capture && w_last) w_state_next = bus.run ? StClear : StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_s_ready   = 1'b0;
    w_fft_load  = 1'b0;
    w_fft_rd    = '0;
    w_fft_start = 1'b0;
    w_fft_reset = 1'b0;
    unique case (r_state)
      StClear: w_fft_reset = 1'b1;
      StLoad: begin
        w_s_ready  = 1'b1;
        w_fft_load = bus.s_valid;
        w_fft_rd   = bus.s_data;
      end
      StStart: w_fft_start = 1'b1;
      default: ;
    endcase
  end

  // One counter indexes samples while loading and bins while unloading; it wraps to 0 between.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_m_index     <= '0;
      r_m_last      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_m_valid    <= w_capture;
      r_frame_done <= w_capture && w_last;
      if (w_capture) begin
        r_m_data  <= bus.fft_wd;
        r_m_index <= r_cnt;
        r_m_last  <= w_last;
      end
      if (r_state == StClear) begin
        r_cnt <= '0;
      end else if (w_accept || w_capture) begin
        r_cnt <= r_cnt + N_2'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef FFT_SEQ_OVERRUN_CNT_EN
  logic [OVERRUN_CNT_W-1:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun_cnt <= '0;
    end else if (bus.run && bus.s_valid && !w_s_ready && (r_overrun_cnt != '1)) begin
      r_overrun_cnt <= r_overrun_cnt + OVERRUN_CNT_W'(1);
    end
  end

  assign bus.overrun_cnt = r_overrun_cnt;
`else
  assign bus.overrun_cnt = '0;
`endif

  assign bus.s_ready     = w_s_ready;
  assign bus.fft_load    = w_fft_load;
  assign bus.fft_rd      = w_fft_rd;
  assign bus.fft_start   = w_fft_start;
  assign bus.fft_reset   = w_fft_reset;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.m_index     = r_m_index;
  assign bus.m_last      = r_m_last;
  assign bus.busy        = (r_state != StIdle);
  assign bus.frame_done  = r_frame_done;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/fft_frame_seq.md
# fft_frame_seq

Frame sequencer for the streaming FFT core. It accepts real samples on a valid/ready stream and steps the core through clear, load, start, compute and unload, once per frame. Results leave on a registered, index-tagged output stream. It sits between the ADC/sample front end and the `fft` instance, and continues frame after frame while `run` is held.

## Interface
Parameters:
- `WIDTH`, 16, per-component bit width; must match the core.
- `N_2`, 5, log2 of points per frame (N = 2**N_2).
- `TIMEOUT`, 1024, maximum cycles allowed in WAIT before abort; must be > (N_2+1)*(N/2+1).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `run`  in  1  level; frames loop while high
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  sample accepted when `s_valid & s_ready`
- `s_data`  in  WIDTH  real sample
- `fft_reset`  out  1  core reset pulse
- `fft_load`  out  1  core load strobe
- `fft_rd`  out  WIDTH  core sample input
- `fft_start`  out  1  core start pulse
- `fft_done`  in  1  core done level
- `fft_wd`  in  2*WIDTH  core result {re, im}
- `m_valid`  out  1  result valid; no backpressure
- `m_data`  out  2*WIDTH  result {re, im}
- `m_index`  out  N_2  bin index of `m_data`
- `m_last`  out  1  asserted with index N-1
- `busy`  out  1  state != IDLE
- `frame_done`  out  1  one-cycle pulse when the last result is captured
- `timeout_err`  out  1  sticky; cleared only by `reset`
- `overrun_cnt`  out  16  dropped-sample count (see Configuration)

## Operation
The FSM has six states:
- **IDLE:** leaves to CLEAR when `run`=1.
- **CLEAR:** lasts 1 cycle. `fft_reset`=1, sample counter cleared, then goes to LOAD.
- **LOAD:**
  - `s_ready`=1. `fft_load` = `s_valid`. `fft_rd` = `s_data`, combinational in the same cycle.
  - The counter increments per accepted sample. When the N-th sample is accepted, go to START.
  - If `run` falls during LOAD, the frame is aborted and the FSM goes to IDLE. No start is issued.
- **START:** lasts 1 cycle. `fft_start`=1, watchdog cleared, then goes to WAIT.
- **WAIT:**
  - The watchdog increments each cycle.
  - On the first cycle with `fft_done`=1, capture result index 0 and go to UNLOAD.
  - If the watchdog reaches TIMEOUT, set `timeout_err` and go to IDLE. No output is produced.
- **UNLOAD:**
  - Capture on every cycle while `fft_done`=1; the index increments per capture.
  - After capturing index N-1, pulse `frame_done` and go to CLEAR if `run`=1, else IDLE.
  - Once a frame reaches WAIT or UNLOAD, it always completes regardless of `run`.

Capture means: `m_data` <= `fft_wd`, `m_index` <= k, `m_last` <= (k==N-1), `m_valid` <= 1 on the next edge. In every other cycle `m_valid` <= 0.

Output rules:
- `s_ready`, `fft_load`, `fft_start` and `fft_reset` are 0 outside their states.
- Reset values: every output is 0 and the state is IDLE. `reset` asserted in any state aborts immediately.

## Timing
- Sample-to-core latency: 0 cycles (pass-through).
- Result latency: `m_valid` for index k asserts 1 cycle after the k-th `fft_done` cycle.
- `m_valid` is high for N consecutive cycles per frame. The downstream consumer must accept every cycle.
- Inter-frame gap with `run` held: 1 CLEAR cycle, then LOAD.
- `fft_start` rises exactly 1 cycle after the N-th accepted sample.

## Configuration
Macro: `FFT_SEQ_OVERRUN_CNT_EN`.
- **Defined:** `overrun_cnt` increments when `run`=1, `s_valid`=1 and `s_ready`=0, saturates at 16'hFFFF, and is cleared only by `reset`.
- **Undefined:** `overrun_cnt` is tied to 0 and no counter logic is generated.

## Structure
- The shared package `fft_pkg` holds:
  - the state enum `fft_seq_state_t` (IDLE, CLEAR, LOAD, START, WAIT, UNLOAD);
  - the `cplx_t` typedef for {re, im} of width 2*WIDTH;
  - the overrun counter width constant (16).
- One sub-module, `fft_seq_watchdog`, provides the WAIT cycle counter with clear, enable and expired outputs.
- The FSM, counters and output registers live in the top module.

## Test plan
All scenarios use N_2=5 (N=32).
1. **Single frame:** hold `run` and `s_valid`=1 with an impulse at sample 0 against the real core. Expect 32 `m_valid` beats with `m_index` 0..31, every `m_data` re equal, `m_last` only at 31, and one `frame_done` pulse.
2. **Throttled input:** toggle `s_valid` every other cycle. Expect `fft_load` count = 32 and `fft_start` exactly 1 cycle after the 32nd accepted sample.
3. **Back-to-back frames:** hold `run`=1 across 3 frames. Expect 1-cycle `fft_reset` before each LOAD and 96 total beats.
4. **Timeout:** stub the core with `fft_done` held at 0. Expect `timeout_err`=1 after 1024 WAIT cycles, return to IDLE, and no `m_valid`.
5. **Aborts:**
   - Drop `run` at sample 10: expect IDLE with no `fft_start`.
   - Assert `reset` mid-UNLOAD: expect all outputs 0 on the next cycle.
6. **Overrun** (macro defined): hold `s_valid`=1 through 40 non-LOAD cycles while `run`=1. Expect `overrun_cnt`=40. With the macro undefined, expect 0.
